// File: rtl/param_timer.sv
// param_timer: prescaled down-counter that can run once or reload itself.
// A prescaler divides clk by PRESCALE_DIV into ticks. Each tick decrements
// the count, and expired pulses for one cycle when the count reaches its end.
module param_timer #(
  parameter int          CNT_W        = 8,
  parameter int unsigned PRESCALE_DIV = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] value_input,
  input  logic             startTimer,
  input  logic             stopTimer,
  input  logic             pause,
  input  logic             periodic,
  output logic             expired,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  // A divider of 1 still needs a 1-bit prescaler. It then stays at 0, so every cycle is a tick.
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE_DIV - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    psc, psc_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] reload, reload_n;
  logic             per, per_n;
  logic             exp_q, exp_n;
  logic             tick;

  // Tick fires on the cycle the prescaler wraps, and only while running and not paused.
  assign tick = (state == RUN) && !pause && (psc == PSC_LAST);

  // State register and datapath registers. Reset is asynchronous and clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      psc    <= '0;
      count  <= '0;
      reload <= '0;
      per    <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      state  <= state_n;
      psc    <= psc_n;
      count  <= count_n;
      reload <= reload_n;
      per    <= per_n;
      exp_q  <= exp_n;
    end
  end

  // Next-state logic. Inputs are prioritised: start first, then stop, then pause.
  always_comb begin
    state_n  = state;
    psc_n    = psc;
    count_n  = count;
    reload_n = reload;
    per_n    = per;
    exp_n    = 1'b0;
    if (startTimer) begin
      // A start also overrides a terminal tick on the same edge, so it suppresses that expiry.
      count_n  = value_input;
      reload_n = value_input;
      psc_n    = '0;
      if (value_input == '0) begin
        // A zero load expires immediately and never enters RUN.
        per_n   = 1'b0;
        exp_n   = 1'b1;
        state_n = IDLE;
      end else begin
        per_n   = periodic;
        state_n = RUN;
      end
    end else if (state == RUN) begin
      if (stopTimer) begin
        // Abort: keep the count visible, drop any partial prescale.
        state_n = IDLE;
        psc_n   = '0;
      end else if (!pause) begin
        psc_n = tick ? '0 : psc + 1'b1;
        if (tick) begin
          if (count > CNT_W'(1)) begin
            count_n = count - 1'b1;
          end else begin
            // Terminal tick. A count of 0 is treated like 1, so the count cannot underflow.
            exp_n = 1'b1;
            if (per) begin
              count_n = reload;
            end else begin
              count_n = '0;
              state_n = IDLE;
            end
          end
        end
      end
    end
  end

  assign expired   = exp_q;
  assign busy      = (state == RUN);
  assign remaining = count;

endmodule

// File: tb/tb_param_timer.sv
// Directed bench for param_timer with CNT_W=4, PRESCALE_DIV=4.
// Edge 0 is the edge that samples startTimer. Outputs are sampled 1ns after each edge.
module tb_param_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] value_input;
  logic       startTimer, stopTimer, pause, periodic;
  logic       expired, busy;
  logic [3:0] remaining;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  param_timer #(.CNT_W(4), .PRESCALE_DIV(4)) dut (
    .clk(clk), .reset(reset), .value_input(value_input),
    .startTimer(startTimer), .stopTimer(stopTimer), .pause(pause),
    .periodic(periodic), .expired(expired), .busy(busy), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive a one-cycle start. On return, the start edge has just occurred and cyc is 0.
  task automatic start(input logic [3:0] v, input logic p);
    value_input = v;
    periodic    = p;
    startTimer  = 1'b1;
    tick();
    startTimer  = 1'b0;
    cyc = 0;
  endtask

  initial begin
    reset = 1'b1; value_input = '0; startTimer = 0; stopTimer = 0; pause = 0; periodic = 0;
    tick(); tick();
    chk("rst_expired", expired, 0);
    chk("rst_busy", busy, 0);
    chk("rst_remaining", remaining, 0);
    reset = 1'b0;
    tick();

    // One-shot with a load of 3: expires at edge 12.
    start(4'd3, 1'b0);
    chk("os_busy0", busy, 1);
    chk("os_rem0", remaining, 3);
    while (cyc < 14) begin
      tick();
      chk("os_expired", expired, cyc == 12);
      if (cyc == 4)  chk("os_rem4", remaining, 2);
      if (cyc == 11) chk("os_busy11", busy, 1);
      if (cyc == 13) begin
        chk("os_busy_end", busy, 0);
        chk("os_rem_end", remaining, 0);
      end
    end

    // Periodic with a load of 2: pulses at edges 8 and 16. A stop sampled at edge 21 cancels the pulse at 24.
    start(4'd2, 1'b1);
    while (cyc < 30) begin
      tick();
      chk("per_expired", expired, (cyc == 8) || (cyc == 16));
      if (cyc <= 20) chk("per_busy", busy, 1);
      if (cyc == 20) stopTimer = 1'b1;
      if (cyc == 21) stopTimer = 1'b0;
      if (cyc > 21) begin
        chk("per_stop_busy", busy, 0);
        chk("per_stop_rem", remaining, 1);
      end
    end

    // One-shot of 3, paused for 10 edges: expiry moves from edge 12 to edge 22.
    start(4'd3, 1'b0);
    while (cyc < 25) begin
      tick();
      chk("pause_expired", expired, cyc == 22);
      if (cyc == 5)  pause = 1'b1;
      if (cyc == 15) pause = 1'b0;
      if (cyc == 10) chk("pause_rem", remaining, 2);
    end

    // A zero load expires on the next cycle and never raises busy.
    start(4'd0, 1'b1);
    chk("zero_expired", expired, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_expired_end", expired, 0);
    chk("zero_busy_end", busy, 0);

    // Restart at edge 10 of a 3-tick run with a load of 5: expires at edge 30, and no pulse at edge 12.
    start(4'd3, 1'b0);
    while (cyc < 32) begin
      if (cyc == 9) begin
        value_input = 4'd5;
        startTimer  = 1'b1;
      end
      tick();
      if (cyc == 10) begin
        startTimer = 1'b0;
        chk("rs_rem", remaining, 5);
      end
      chk("rs_expired", expired, cyc == 30);
    end
    chk("rs_busy_end", busy, 0);

    // Asynchronous reset mid-cycle while the count is 2: outputs clear before the next edge.
    start(4'd3, 1'b1);
    while (cyc < 5) tick();
    chk("ar_rem_pre", remaining, 2);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_rem", remaining, 0);
    chk("ar_expired", expired, 0);
    #2;
    reset = 1'b0;
    while (cyc < 25) begin
      tick();
      chk("ar_no_expired", expired, 0);
      chk("ar_idle", busy, 0);
    end

    // A start of 1 on the terminal-tick edge of a count of 3: no pulse at 12, pulse at 16.
    start(4'd3, 1'b0);
    while (cyc < 18) begin
      if (cyc == 11) begin
        value_input = 4'd1;
        startTimer  = 1'b1;
      end
      tick();
      if (cyc == 12) begin
        startTimer = 1'b0;
        chk("tt_rem", remaining, 1);
        chk("tt_busy", busy, 1);
      end
      chk("tt_expired", expired, cyc == 16);
    end
    chk("tt_busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/param_timer.md
PARAM_TIMER -- requirements
Module: param_timer

Interface
REQ-001 Parameter CNT_W, 8: width of load value and remaining count.
REQ-002 Parameter PRESCALE_DIV, 50000000: clk cycles per timer tick; legal range 1 to 2^32-1.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port value_input  input  CNT_W  tick count to load; sampled only when startTimer is high.
REQ-006 Port startTimer  input  1  load value_input and (re)start counting.
REQ-007 Port stopTimer  input  1  abort countdown to IDLE without expiry.
REQ-008 Port pause  input  1  freeze prescaler and count while high.
REQ-009 Port periodic  input  1  mode: 0 one-shot, 1 auto-reload; sampled with startTimer.
REQ-010 Port expired  output  1  registered one-cycle pulse at terminal count.
REQ-011 Port busy  output  1  high in RUN state.
REQ-012 Port remaining  output  CNT_W  current count value.

Function
REQ-013 The block SHALL implement states IDLE and RUN.
REQ-014 Input priority SHALL be reset > startTimer > stopTimer > pause.
REQ-015 startTimer high at an edge, any state, SHALL load count and reload register from value_input, latch periodic, clear prescaler, enter RUN (restart if already running).
REQ-016 If value_input is 0 at start, the block SHALL pulse expired the following cycle, stay/return to IDLE, and ignore periodic.
REQ-017 In RUN with pause low, prescaler SHALL increment each cycle and wrap from PRESCALE_DIV-1 to 0, generating a tick on the wrap edge.
REQ-018 On each tick with count > 1, count SHALL decrement by 1.
REQ-019 On a tick with count == 1, expired SHALL be high for exactly the next cycle; first pulse rises value_input*PRESCALE_DIV cycles after the start edge.
REQ-020 At expiry, one-shot SHALL set count 0 and go IDLE; periodic SHALL reload count from reload register in the same edge and stay RUN, giving period reload*PRESCALE_DIV cycles with no gap.
REQ-021 pause high in RUN SHALL hold prescaler and count; release resumes without losing partial prescale cycles.
REQ-022 stopTimer in RUN (no start) SHALL go IDLE, clear prescaler, hold remaining, and suppress expired.
REQ-023 startTimer on the same edge as a terminal tick SHALL win: no expired pulse, new value loaded.
REQ-024 In IDLE, stopTimer and pause SHALL have no effect; count SHALL hold.
REQ-025 Arithmetic SHALL never underflow; count never wraps below 0.
REQ-026 Prescaler width SHALL be $clog2(PRESCALE_DIV) bits, minimum 1; PRESCALE_DIV=1 ticks every cycle.

Reset
REQ-027 reset high SHALL immediately force IDLE, prescaler 0, count 0, reload register 0, periodic latch 0, expired 0, busy 0, remaining 0, independent of clk.
REQ-028 Reset asserted mid-countdown SHALL abort with no expired pulse; first activity after release requires a new startTimer.

Verification (CNT_W=4, PRESCALE_DIV=4)
REQ-029 Reset release, value_input=3, startTimer 1 cycle, periodic=0 -> expired single pulse 12 cycles after start edge, busy low afterwards, remaining=0.
REQ-030 value_input=2, periodic=1 -> expired pulses at 8, 16, 24 cycles after start; busy stays high; stopTimer at cycle 20 -> no pulse at 24, remaining=1 holds.
REQ-031 value_input=3 one-shot, pause high cycles 5-14 -> expired at cycle 22 instead of 12.
REQ-032 value_input=0 start -> expired next cycle, busy never high; value_input=5 restart at cycle 10 of a 3-tick run -> first expiry 20 cycles after restart, none at cycle 12.
REQ-033 Async reset pulse mid-cycle during RUN at count=2 -> all outputs 0 before next clk edge, no later expired pulse.
REQ-034 startTimer with value_input=1 on the terminal-tick edge of a running count -> no pulse that cycle, expired 4 cycles later.
